// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative fixed-point divider.
// The quantisation constants match the rest of the datapath.
package div_pkg;

  localparam int unsigned QUANT_BITS = 10;
  localparam int unsigned QUANT_VAL  = 32'd1 << QUANT_BITS;

  // Widest magnitude the saturation helper handles.
  localparam int unsigned SAT_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Applies a sign to an unsigned magnitude and clamps the result to a qw-bit signed range.
  function automatic logic [SAT_W-1:0] sat_signed(
    input  logic [SAT_W-1:0] mag,
    input  logic             neg,
    input  int unsigned      qw,
    output logic             ovf
  );
    logic [SAT_W-1:0] max_pos;
    logic [SAT_W-1:0] res;
    max_pos = (SAT_W'(1) << (qw - 1)) - SAT_W'(1);
    ovf     = 1'b0;
    if (!neg) begin
      if (mag > max_pos) begin
        res = max_pos;
        ovf = 1'b1;
      end else begin
        res = mag;
      end
    end else if (mag > max_pos + SAT_W'(1)) begin
      res = ~max_pos;
      ovf = 1'b1;
    end else begin
      res = SAT_W'(0) - mag;
    end
    return res;
  endfunction

endpackage

// File: rtl/div_sat.sv
// Applies result signs to the final quotient/remainder magnitudes and saturates the quotient.
// A zero divisor forces a full-scale quotient in the direction of the dividend's sign.
module div_sat
  import div_pkg::*;
#(
  parameter int unsigned QUOTIENT_WIDTH = 32,
  parameter int unsigned MAG_WIDTH      = 32,
  parameter int unsigned REM_WIDTH      = 32
) (
  input  logic [MAG_WIDTH-1:0]      q_mag,
  input  logic                      q_neg,
  input  logic [REM_WIDTH-1:0]      r_mag,
  input  logic                      r_neg,
  input  logic                      zero_div,
  output logic [QUOTIENT_WIDTH-1:0] quotient_c,
  output logic [REM_WIDTH-1:0]      remainder_c,
  output logic                      overflow_c
);

  logic             sat_ovf;
  logic [SAT_W-1:0] mag_ext;

  always_comb begin
    sat_ovf     = 1'b0;
    mag_ext     = zero_div ? {SAT_W{1'b1}} : SAT_W'(q_mag);
    quotient_c  = QUOTIENT_WIDTH'(sat_signed(mag_ext, q_neg, QUOTIENT_WIDTH, sat_ovf));
    overflow_c  = sat_ovf | zero_div;
    remainder_c = zero_div ? '0 : (r_neg ? REM_WIDTH'(0) - r_mag : r_mag);
  end

endmodule

// File: rtl/div_fxp_iter.sv
// Iterative signed fixed-point restoring divider with valid/ready on both sides.
// One operation in flight; the dividend is pre-scaled by FRAC_BITS before dividing.
module div_fxp_iter
  import div_pkg::*;
#(
  parameter int unsigned DIVIDEND_WIDTH = 32,
  parameter int unsigned DIVISOR_WIDTH  = 32,
  parameter int unsigned QUOTIENT_WIDTH = 32,
  parameter int unsigned FRAC_BITS      = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [QUOTIENT_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      overflow,
  output logic                      div_by_zero
);

  localparam int unsigned STEPS = DIVIDEND_WIDTH + FRAC_BITS;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);

  div_state_t state, state_next;

  logic [CNT_W-1:0]          cnt;
  logic [STEPS-1:0]          work;
  logic [DIVISOR_WIDTH-1:0]  part_rem;
  logic [DIVISOR_WIDTH-1:0]  dvs;
  logic                      q_neg;
  logic                      r_neg;
  logic                      zero_div;

  logic                      accept_c;
  logic                      last_c;
  logic                      divisor_zero_c;
  logic [DIVIDEND_WIDTH-1:0] dividend_abs_c;
  logic [DIVISOR_WIDTH-1:0]  divisor_abs_c;
  logic [DIVISOR_WIDTH:0]    rem_shift_c;
  logic [DIVISOR_WIDTH:0]    rem_diff_c;
  logic [QUOTIENT_WIDTH-1:0] quotient_c;
  logic [DIVISOR_WIDTH-1:0]  remainder_c;
  logic                      overflow_c;

  assign accept_c       = in_valid && in_ready;
  assign last_c         = (cnt == CNT_W'(STEPS));
  assign divisor_zero_c = (divisor == '0);
  assign dividend_abs_c = dividend[DIVIDEND_WIDTH-1] ? DIVIDEND_WIDTH'(0) - dividend : dividend;
  assign divisor_abs_c  = divisor[DIVISOR_WIDTH-1] ? DIVISOR_WIDTH'(0) - divisor : divisor;

  // Restoring step: bring in the next dividend bit, subtract if the divisor fits.
  assign rem_shift_c = {part_rem, work[STEPS-1]};
  assign rem_diff_c  = rem_shift_c - {1'b0, dvs};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_c) state_next = BUSY;
      BUSY:    if (last_c) state_next = DONE;
      DONE:    if (out_valid && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A zero divisor preloads the counter so the result lands one cycle after accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      work        <= '0;
      part_rem    <= '0;
      dvs         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      zero_div    <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
      if (accept_c) begin
        work     <= STEPS'(dividend_abs_c) << FRAC_BITS;
        part_rem <= '0;
        dvs      <= divisor_abs_c;
        zero_div <= divisor_zero_c;
        r_neg    <= dividend[DIVIDEND_WIDTH-1];
        q_neg    <= divisor_zero_c ? dividend[DIVIDEND_WIDTH-1]
                                   : dividend[DIVIDEND_WIDTH-1] ^ divisor[DIVISOR_WIDTH-1];
        cnt      <= divisor_zero_c ? CNT_W'(STEPS) : '0;
      end else if (state == BUSY) begin
        if (!last_c) begin
          cnt <= cnt + CNT_W'(1);
          if (!rem_diff_c[DIVISOR_WIDTH]) begin
            part_rem <= rem_diff_c[DIVISOR_WIDTH-1:0];
            work     <= {work[STEPS-2:0], 1'b1};
          end else begin
            part_rem <= rem_shift_c[DIVISOR_WIDTH-1:0];
            work     <= {work[STEPS-2:0], 1'b0};
          end
        end else begin
          quotient    <= quotient_c;
          remainder   <= remainder_c;
          overflow    <= overflow_c;
          div_by_zero <= zero_div;
        end
      end
    end
  end

  div_sat #(
    .QUOTIENT_WIDTH(QUOTIENT_WIDTH),
    .MAG_WIDTH     (STEPS),
    .REM_WIDTH     (DIVISOR_WIDTH)
  ) u_sat (
    .q_mag      (work),
    .q_neg      (q_neg),
    .r_mag      (part_rem),
    .r_neg      (r_neg),
    .zero_div   (zero_div),
    .quotient_c (quotient_c),
    .remainder_c(remainder_c),
    .overflow_c (overflow_c)
  );

endmodule

// File: tb/tb_div_fxp_iter.sv
// Randomised and directed checks of div_fxp_iter (integer and Q10 instances) against an
// arithmetic reference model, with a per-cycle compare of handshake and result outputs.
module tb_div_fxp_iter;

  typedef struct packed {
    logic        in_ready;
    logic        out_valid;
    logic        ovf;
    logic        dbz;
    logic [31:0] q;
    logic [31:0] r;
  } obs_t;

  typedef struct {
    longint q;
    longint r;
    logic   ovf;
    logic   dbz;
    int     lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv   [2];
  logic        ordy [2];
  logic [31:0] a_in [2];
  logic [31:0] b_in [2];

  logic        ir0, ov0, of0, dz0, ir1, ov1, of1, dz1;
  logic [31:0] q0, r0, q1, r1;
  obs_t        obs [2];

  int   n_assert = 0;
  int   n_fail   = 0;
  logic pending [2];
  exp_t exp_c   [2];
  int   acc     [2];
  int   negcnt = 0;

  longint ta  [7] = '{-64'sd9170000, -64'sd7, 64'sd7, 64'sd0, -64'sd2147483648, 64'sd5, -64'sd5};
  longint tb  [7] = '{64'sd10, 64'sd2, -64'sd2, -64'sd5, -64'sd1, 64'sd0, 64'sd0};
  longint tq  [7] = '{-64'sd917000, -64'sd3, -64'sd3, 64'sd0, 64'sd2147483647,
                      64'sd2147483647, -64'sd2147483648};
  longint tr  [7] = '{64'sd0, -64'sd1, 64'sd1, 64'sd0, 64'sd0, 64'sd0, 64'sd0};
  int     tov [7] = '{0, 0, 0, 0, 1, 1, 1};
  int     tdz [7] = '{0, 0, 0, 0, 0, 1, 1};
  int     tl  [7] = '{33, 33, 33, 33, 33, 1, 1};

  always #5 clk = ~clk;

  always_comb begin
    obs[0] = {ir0, ov0, of0, dz0, q0, r0};
    obs[1] = {ir1, ov1, of1, dz1, q1, r1};
  end

  div_fxp_iter u_div_int (
    .clk(clk), .reset(rst), .in_valid(iv[0]), .in_ready(ir0), .dividend(a_in[0]),
    .divisor(b_in[0]), .out_valid(ov0), .out_ready(ordy[0]), .quotient(q0),
    .remainder(r0), .overflow(of0), .div_by_zero(dz0)
  );

  div_fxp_iter #(.FRAC_BITS(10)) u_div_q10 (
    .clk(clk), .reset(rst), .in_valid(iv[1]), .in_ready(ir1), .dividend(a_in[1]),
    .divisor(b_in[1]), .out_valid(ov1), .out_ready(ordy[1]), .quotient(q1),
    .remainder(r1), .overflow(of1), .div_by_zero(dz1)
  );

  function automatic longint sq(input logic [31:0] x);
    return longint'($signed(x));
  endfunction

  // Reference: scale, divide magnitudes, apply truncation signs, clamp to 32-bit signed.
  function automatic exp_t model(input longint a, input longint b, input int frac);
    exp_t   e;
    longint num, den, qm, rm, qs;
    longint maxq = 64'sd2147483647;
    longint minq = -64'sd2147483648;
    if (b == 0) begin
      e.q = (a < 0) ? minq : maxq;
      e.r = 0; e.ovf = 1'b1; e.dbz = 1'b1; e.lat = 1;
      return e;
    end
    num = (a < 0 ? -a : a) <<< frac;
    den = (b < 0) ? -b : b;
    qm  = num / den;
    rm  = num % den;
    qs  = ((a < 0) != (b < 0)) ? -qm : qm;
    e.r   = (a < 0) ? -rm : rm;
    e.dbz = 1'b0;
    e.ovf = (qs > maxq) || (qs < minq);
    e.q   = (qs > maxq) ? maxq : ((qs < minq) ? minq : qs);
    e.lat = 32 + frac + 1;
    return e;
  endfunction

  task automatic chk(input string nm, input longint act, input longint expv);
    n_assert++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair, wait for its result, and leave after the following edge.
  task automatic run(input int d, input longint a, input longint b, output obs_t o, output int lat);
    int n;
    n = 0;
    while (!obs[d].in_ready && n < 100) begin
      step();
      n++;
    end
    chk("in_ready_before_accept", obs[d].in_ready, 1);
    iv[d]   = 1'b1;
    a_in[d] = 32'(a);
    b_in[d] = 32'(b);
    step();
    iv[d]   = 1'b0;
    a_in[d] = $urandom;
    b_in[d] = $urandom;
    lat = 0;
    @(negedge clk);
    while (!obs[d].out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("result_timeout", obs[d].out_valid, 1);
    o = obs[d];
    step();
  endtask

  initial begin
    obs_t   o;
    int     lat, d, hold;
    longint a, b;

    iv   = '{1'b0, 1'b0};
    ordy = '{1'b1, 1'b1};
    a_in = '{32'd0, 32'd0};
    b_in = '{32'd0, 32'd0};
    pending = '{1'b0, 1'b0};
    acc     = '{0, 0};

    // Cycle-by-cycle compare of both instances against the model.
    fork
      forever begin
        @(negedge clk);
        negcnt++;
        for (int k = 0; k < 2; k++) begin
          if (rst) begin
            pending[k] = 1'b0;
            continue;
          end
          chk($sformatf("dut%0d_in_ready", k), obs[k].in_ready, !pending[k]);
          chk($sformatf("dut%0d_out_valid", k), obs[k].out_valid,
              pending[k] && (negcnt - acc[k] >= exp_c[k].lat + 1));
          if (obs[k].out_valid && pending[k]) begin
            chk($sformatf("dut%0d_quotient", k), sq(obs[k].q), exp_c[k].q);
            chk($sformatf("dut%0d_remainder", k), sq(obs[k].r), exp_c[k].r);
            chk($sformatf("dut%0d_overflow", k), obs[k].ovf, exp_c[k].ovf);
            chk($sformatf("dut%0d_div_by_zero", k), obs[k].dbz, exp_c[k].dbz);
          end
          if (obs[k].out_valid && ordy[k]) pending[k] = 1'b0;
          if (iv[k] && obs[k].in_ready) begin
            pending[k] = 1'b1;
            exp_c[k]   = model(sq(a_in[k]), sq(b_in[k]), (k == 1) ? 10 : 0);
            acc[k]     = negcnt;
          end
        end
      end
    join_none

    repeat (3) step();
    chk("reset_in_ready", obs[0].in_ready, 1);
    chk("reset_out_valid", obs[0].out_valid, 0);
    chk("reset_quotient", sq(obs[0].q), 0);
    chk("reset_remainder", sq(obs[0].r), 0);
    chk("reset_overflow", obs[0].ovf, 0);
    chk("reset_div_by_zero", obs[0].dbz, 0);
    rst = 1'b0;
    step();

    chk("model_pin_q", model(-64'sd7, 64'sd2, 0).q, -64'sd3);
    chk("model_pin_r", model(64'sd7, -64'sd2, 0).r, 64'sd1);
    chk("model_pin_q10", model(64'sd3072, 64'sd2048, 10).q, 64'sd1536);

    for (int i = 0; i < 7; i++) begin
      run(0, ta[i], tb[i], o, lat);
      chk($sformatf("dir%0d_quotient", i), sq(o.q), tq[i]);
      chk($sformatf("dir%0d_remainder", i), sq(o.r), tr[i]);
      chk($sformatf("dir%0d_overflow", i), o.ovf, tov[i]);
      chk($sformatf("dir%0d_div_by_zero", i), o.dbz, tdz[i]);
      chk($sformatf("dir%0d_latency", i), lat, tl[i]);
    end

    run(1, 64'sd3072, 64'sd2048, o, lat);
    chk("q10_quotient", sq(o.q), 1536);
    chk("q10_overflow", o.ovf, 0);
    chk("q10_latency", lat, 43);
    run(1, 64'sd1, 64'sd3, o, lat);
    chk("q10_third_quotient", sq(o.q), 341);
    chk("q10_third_remainder", sq(o.r), 1);

    // Backpressure: result must hold while the consumer stalls.
    ordy[0] = 1'b0;
    run(0, 64'sd1000, -64'sd3, o, lat);
    chk("bp_quotient", sq(o.q), -333);
    chk("bp_remainder", sq(o.r), 1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_valid", obs[0].out_valid, 1);
      chk("bp_hold_in_ready", obs[0].in_ready, 0);
      chk("bp_hold_quotient", sq(obs[0].q), -333);
      step();
    end
    ordy[0] = 1'b1;
    step();
    ordy[0] = 1'b0;
    chk("bp_release_in_ready", obs[0].in_ready, 1);
    chk("bp_release_out_valid", obs[0].out_valid, 0);
    ordy[0] = 1'b1;
    run(0, 64'sd100, -64'sd7, o, lat);
    chk("bp_second_quotient", sq(o.q), -14);
    chk("bp_second_remainder", sq(o.r), 2);

    // Reset in the middle of an iteration.
    iv[0] = 1'b1; a_in[0] = 32'd123456; b_in[0] = 32'd7;
    step();
    iv[0] = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    #1;
    chk("midreset_out_valid", obs[0].out_valid, 0);
    chk("midreset_in_ready", obs[0].in_ready, 1);
    step();
    rst = 1'b0;
    run(0, 64'sd100, 64'sd7, o, lat);
    chk("post_reset_quotient", sq(o.q), 14);
    chk("post_reset_remainder", sq(o.r), 2);

    for (int i = 0; i < 160; i++) begin
      d = i % 2;
      case ($urandom_range(0, 4))
        0: begin
          a = longint'($urandom_range(0, 2000)) - 1000;
          b = longint'($urandom_range(0, 40)) - 20;
        end
        1: begin
          a = sq($urandom);
          b = longint'($urandom_range(0, 200)) - 100;
        end
        2: begin
          a = sq($urandom);
          b = sq($urandom);
        end
        3: begin
          a = sq($urandom);
          b = longint'($urandom_range(0, 2)) - 1;
        end
        default: begin
          a = -64'sd2147483648;
          b = sq($urandom) >>> $urandom_range(0, 31);
        end
      endcase
      hold    = $urandom_range(0, 3);
      ordy[d] = (hold == 0);
      run(d, a, b, o, lat);
      if (hold != 0) begin
        repeat (hold) step();
        ordy[d] = 1'b1;
        step();
      end
    end

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
